alarm_tone_gen: RTL

//  Parametrised alarm-tone generator and mixer for the dispenser audio path.

---
 rtl/alarm_tone_gen.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/alarm_tone_gen.sv
// Alarm-tone generator and stereo mixer: timed beep/gap/pause bursts, tone summed with saturation.
// Optional build macro ALARM_ATTACK_RAMP_EN adds a linear attack ramp at the start of each beep.
module alarm_tone_gen #(
  parameter int SAMPLE_W  = 32,
  parameter int AMPLITUDE = 10000000,
  parameter int TONE_HALF = 35768,
  parameter int BEEP_CYC  = 12000000,
  parameter int GAP_CYC   = 12000000,
  parameter int BURSTS    = 3,
  parameter int PAUSE_CYC = 50000000,
  parameter int CNT_W     = 27
) (
  input  logic                       CLOCK_50,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       ack,
  input  logic                       audio_in_available,
  input  logic                       audio_out_allowed,
  input  logic signed [SAMPLE_W-1:0] left_channel_audio_in,
  input  logic signed [SAMPLE_W-1:0] right_channel_audio_in,
  output logic                       read_audio_in,
  output logic                       write_audio_out,
  output logic signed [SAMPLE_W-1:0] left_channel_audio_out,
  output logic signed [SAMPLE_W-1:0] right_channel_audio_out,
  output logic                       active,
  output logic [7:0]                 beep_idx
);

  typedef enum logic [1:0] {IDLE, BEEP, GAP, PAUSE} state_t;

  localparam logic signed [SAMPLE_W-1:0] AMP = SAMPLE_W'(AMPLITUDE);

  state_t                     r_state;
  logic [CNT_W-1:0]           r_cnt;
  logic [CNT_W-1:0]           r_tone_cnt;
  logic                       r_pol;
  logic                       r_acked;
  logic [7:0]                 r_beep_idx;

  logic                       w_abort;
  logic                       w_beep_done;
  logic                       w_enter_beep;
  logic signed [SAMPLE_W-1:0] w_mag;
  logic signed [SAMPLE_W-1:0] w_tone;
  logic signed [SAMPLE_W:0]   w_sum_l;
  logic signed [SAMPLE_W:0]   w_sum_r;

  function automatic logic signed [SAMPLE_W-1:0] sat(input logic signed [SAMPLE_W:0] v);
    if (v[SAMPLE_W] != v[SAMPLE_W-1])
      sat = v[SAMPLE_W] ? {1'b1, {(SAMPLE_W-1){1'b0}}} : {1'b0, {(SAMPLE_W-1){1'b1}}};
    else
      sat = v[SAMPLE_W-1:0];
  endfunction

  // Abort beats every timed transition; entering BEEP can come from IDLE, GAP or PAUSE.
  assign w_abort      = (r_state != IDLE) && (!enable || ack);
  assign w_beep_done  = (r_state == BEEP) && (r_cnt == CNT_W'(BEEP_CYC - 1));
  assign w_enter_beep = !w_abort &&
                        (((r_state == IDLE)  && enable && !r_acked && !ack) ||
                         ((r_state == GAP)   && (r_cnt == CNT_W'(GAP_CYC - 1))) ||
                         ((r_state == PAUSE) && (r_cnt == CNT_W'(PAUSE_CYC - 1))));

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_tone_cnt <= '0;
      r_pol      <= 1'b1;
      r_acked    <= 1'b0;
      r_beep_idx <= '0;
    end else begin
      r_acked <= enable && (r_acked || ack);
      if (w_abort) begin
        r_state    <= IDLE;
        r_cnt      <= '0;
        r_beep_idx <= '0;
      end else if (w_enter_beep) begin
        r_state    <= BEEP;
        r_cnt      <= '0;
        r_tone_cnt <= '0;
        r_pol      <= 1'b1;
        if (r_state == IDLE)
          r_beep_idx <= '0;
      end else begin
        case (r_state)
          BEEP: begin
            if (r_tone_cnt == CNT_W'(TONE_HALF - 1)) begin
              r_tone_cnt <= '0;
              r_pol      <= ~r_pol;
            end else begin
              r_tone_cnt <= r_tone_cnt + CNT_W'(1);
            end
            if (w_beep_done) begin
              r_cnt <= '0;
              if (r_beep_idx == 8'(BURSTS - 1)) begin
                r_state    <= PAUSE;
                r_beep_idx <= '0;
              end else begin
                r_state    <= GAP;
                r_beep_idx <= r_beep_idx + 8'd1;
              end
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          GAP, PAUSE: r_cnt <= r_cnt + CNT_W'(1);
          default:    r_cnt <= '0;
        endcase
      end
    end
  end

`ifdef ALARM_ATTACK_RAMP_EN
  localparam logic signed [SAMPLE_W-1:0] STEP = SAMPLE_W'(AMPLITUDE >> 10);

  logic signed [SAMPLE_W-1:0] r_mag;

  // Magnitude for beep cycle k is (k+1)*STEP, pinned to AMP from cycle 1023 on.
  always_ff @(posedge CLOCK_50) begin
    if (reset)
      r_mag <= '0;
    else if (w_enter_beep)
      r_mag <= STEP;
    else if ((r_state == BEEP) && !w_abort && !w_beep_done)
      r_mag <= (r_cnt >= CNT_W'(1022)) ? AMP : r_mag + STEP;
    else
      r_mag <= '0;
  end

  assign w_mag = r_mag;
`else
  assign w_mag = AMP;
`endif

  assign w_tone   = (r_state == BEEP) ? (r_pol ? w_mag : -w_mag) : '0;
  assign w_sum_l  = (SAMPLE_W+1)'(left_channel_audio_in)  + (SAMPLE_W+1)'(w_tone);
  assign w_sum_r  = (SAMPLE_W+1)'(right_channel_audio_in) + (SAMPLE_W+1)'(w_tone);

  assign left_channel_audio_out  = sat(w_sum_l);
  assign right_channel_audio_out = sat(w_sum_r);
  assign read_audio_in           = audio_in_available & audio_out_allowed;
  assign write_audio_out         = audio_in_available & audio_out_allowed;
  assign active                  = (r_state != IDLE);
  assign beep_idx                = r_beep_idx;

endmodule
